// File: rtl/iic_config_sequencer.sv
// Walks a register/data table and issues one I2C write per entry through the
// IIC_Avalon slave, with NACK/start-timeout retry and sticky Done/Error status.
module iic_config_sequencer #(
    parameter int          NUM_REGS      = 10,
    parameter int          IDX_W         = 4,
    parameter logic [7:0]  DEV_ADDR      = 8'h34,
    parameter int          GAP_CYCLES    = 5000,
    parameter int          START_TIMEOUT = 255,
    parameter int          MAX_RETRY     = 3
) (
    input  logic             Clk_In,
    input  logic             Reset,
    input  logic             Start,
    output logic [IDX_W-1:0] Tbl_Index,
    input  logic [15:0]      Tbl_Data,
    output logic [1:0]       Avalon_Address,
    output logic [7:0]       Avalon_Writedata,
    output logic             Avalon_Write,
    input  logic             Iic_Busy,
    input  logic             Iic_Nack,
    output logic             Busy,
    output logic             Done,
    output logic             Error,
    output logic [IDX_W-1:0] Err_Index,
    output logic [9:0]       LEDR
);

    // state      | meaning
    // IDLE       | waiting for Start after reset
    // FETCH      | latch table entry
    // WR_DATA    | Avalon write: addr 0, reg_data
    // WR_REG     | Avalon write: addr 1, reg_addr
    // WR_DEV     | Avalon write: addr 2, device address
    // WR_GO      | Avalon write: addr 3, go
    // WAIT_START | waiting for Iic_Busy to rise (bounded)
    // WAIT_END   | waiting for Iic_Busy to fall, then check NACK
    // GAP        | inter-transaction idle time
    // FIN        | all entries acknowledged
    // ERR        | retries exhausted
    typedef enum logic [3:0] {
        IDLE, FETCH, WR_DATA, WR_REG, WR_DEV, WR_GO,
        WAIT_START, WAIT_END, GAP, FIN, ERR
    } state_t;

    localparam int GAP_W = $clog2(GAP_CYCLES + 2);
    localparam int TMO_W = $clog2(START_TIMEOUT + 2);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);
    localparam int LED_W = (IDX_W < 4) ? IDX_W : 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic               pend_q, pend_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [15:0]        entry_q, entry_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic [1:0]         hold_addr_q, hold_addr_d;
    logic [7:0]         hold_data_q, hold_data_d;
    logic               wr;
    logic [1:0]         wr_addr;
    logic [7:0]         wr_data;
    logic               fail;
    logic [3:0]         led_idx;

    always_ff @(posedge Clk_In) begin
        if (Reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            retry_q     <= '0;
            pend_q      <= 1'b0;
            gap_q       <= '0;
            tmo_q       <= '0;
            entry_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_idx_q   <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            pend_q      <= pend_d;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
            entry_q     <= entry_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_idx_q   <= err_idx_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        pend_d      = pend_q;
        gap_d       = gap_q;
        tmo_d       = tmo_q;
        entry_d     = entry_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_idx_d   = err_idx_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        wr          = 1'b0;
        wr_addr     = hold_addr_q;
        wr_data     = hold_data_q;
        fail        = 1'b0;

        case (state_q)
            IDLE, FIN, ERR: begin
                if (Start) begin
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    err_idx_d = '0;
                    idx_d     = '0;
                    retry_d   = '0;
                    pend_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                entry_d = Tbl_Data;
                state_d = WR_DATA;
            end
            WR_DATA: begin
                wr      = 1'b1;
                wr_addr = 2'd0;
                wr_data = entry_q[7:0];
                state_d = WR_REG;
            end
            WR_REG: begin
                wr      = 1'b1;
                wr_addr = 2'd1;
                wr_data = entry_q[15:8];
                state_d = WR_DEV;
            end
            WR_DEV: begin
                wr      = 1'b1;
                wr_addr = 2'd2;
                wr_data = DEV_ADDR;
                state_d = WR_GO;
            end
            WR_GO: begin
                wr      = 1'b1;
                wr_addr = 2'd3;
                wr_data = 8'h01;
                tmo_d   = TMO_W'(START_TIMEOUT - 1);
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (Iic_Busy) begin
                    state_d = WAIT_END;
                end else if (tmo_q == '0) begin
                    fail = 1'b1;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            WAIT_END: begin
                if (!Iic_Busy) begin
                    if (Iic_Nack) begin
                        fail = 1'b1;
                    end else begin
                        retry_d = '0;
                        pend_d  = 1'b0;
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = FETCH;
                end else if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        // Retry re-runs the same entry after the normal inter-transaction gap.
        if (fail) begin
            if (retry_q < RTY_W'(MAX_RETRY)) begin
                retry_d = retry_q + RTY_W'(1);
                pend_d  = 1'b1;
                gap_d   = GAP_W'(GAP_CYCLES - 1);
                state_d = GAP;
            end else begin
                error_d   = 1'b1;
                err_idx_d = idx_q;
                busy_d    = 1'b0;
                state_d   = ERR;
            end
        end

        if (wr) begin
            hold_addr_d = wr_addr;
            hold_data_d = wr_data;
        end
    end

    assign led_idx          = 4'(idx_q[LED_W-1:0]);
    assign Tbl_Index        = idx_q;
    assign Avalon_Write     = wr;
    assign Avalon_Address   = wr_addr;
    assign Avalon_Writedata = wr_data;
    assign Busy             = busy_q;
    assign Done             = done_q;
    assign Error            = error_q;
    assign Err_Index        = err_idx_q;
    assign LEDR             = {error_q, done_q, busy_q, 3'd0, led_idx};

endmodule

// File: tb/tb_iic_config_sequencer.sv
// Directed bench for iic_config_sequencer with a small IIC_Avalon slave model
// and a log of every Avalon write compared against hand-built bursts.
module tb_iic_config_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] tbl_index;
    logic [15:0] tbl_data;
    logic [1:0] avalon_address;
    logic [7:0] avalon_writedata;
    logic       avalon_write;
    logic       iic_busy = 1'b0;
    logic       iic_nack = 1'b0;
    logic       busy, done, error;
    logic [3:0] err_index;
    logic [9:0] ledr;

    int checks = 0;
    int errors = 0;

    logic [15:0] tbl [0:2];
    logic [9:0]  wlog [$];
    logic [9:0]  exp_q [$];

    int mode = 0;     // 0 ack, 1 nack first try of entry 1, 2 entry 0 always nacks, 3 never starts
    bit nacked1 = 0;
    int cnt = 0;

    iic_config_sequencer #(
        .NUM_REGS(3), .IDX_W(4), .DEV_ADDR(8'h34),
        .GAP_CYCLES(4), .START_TIMEOUT(8), .MAX_RETRY(3)
    ) dut (
        .Clk_In(clk), .Reset(rst), .Start(start),
        .Tbl_Index(tbl_index), .Tbl_Data(tbl_data),
        .Avalon_Address(avalon_address), .Avalon_Writedata(avalon_writedata),
        .Avalon_Write(avalon_write), .Iic_Busy(iic_busy), .Iic_Nack(iic_nack),
        .Busy(busy), .Done(done), .Error(error), .Err_Index(err_index), .LEDR(ledr)
    );

    always #5 clk = ~clk;

    initial begin
        tbl[0] = 16'h001A;
        tbl[1] = 16'h021A;
        tbl[2] = 16'h047B;
    end

    assign tbl_data = (tbl_index < 4'd3) ? tbl[tbl_index[1:0]] : 16'h0000;

    always @(negedge clk) begin
        if (avalon_write === 1'b1)
            wlog.push_back({avalon_address, avalon_writedata});
    end

    always @(negedge clk) begin
        if (rst) begin
            cnt = 0;
            iic_busy = 1'b0;
        end else if (avalon_write === 1'b1 && avalon_address == 2'd3) begin
            if (mode != 3) begin
                cnt = 3;
                iic_busy = 1'b1;
                iic_nack = (mode == 2 && tbl_index == 4'd0) ||
                           (mode == 1 && tbl_index == 4'd1 && !nacked1);
                if (mode == 1 && tbl_index == 4'd1) nacked1 = 1;
            end
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) iic_busy = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic add_burst(input logic [15:0] e);
        exp_q.push_back({2'd0, e[7:0]});
        exp_q.push_back({2'd1, e[15:8]});
        exp_q.push_back({2'd2, 8'h34});
        exp_q.push_back({2'd3, 8'h01});
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, wlog.size(), exp_q.size());
        for (int i = 0; i < wlog.size() && i < exp_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), {22'd0, wlog[i]}, {22'd0, exp_q[i]});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_flag(input int max, output int cyc);
        cyc = 0;
        while (!(done || error) && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_erridx"}, err_index, 0);
        check({tag, "_idx"}, tbl_index, 0);
        check({tag, "_wr"}, avalon_write, 0);
        check({tag, "_addr"}, avalon_address, 0);
        check({tag, "_wdata"}, avalon_writedata, 0);
        check({tag, "_ledr"}, ledr, 0);
    endtask

    initial begin
        int cyc;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean run, all entries ACKed
        mode = 0;
        wlog.delete(); exp_q.delete();
        add_burst(16'h001A); add_burst(16'h021A); add_burst(16'h047B);
        pulse_start();
        wait_flag(500, cyc);
        check("ack_latency", cyc, 36);
        check("ack_done", done, 1);
        check("ack_busy", busy, 0);
        check("ack_error", error, 0);
        check("ack_ledr", ledr, 10'b0100000010);
        compare_log("ack");

        // NACK once on entry 1; Start from FIN reruns; Start while busy ignored
        mode = 1; nacked1 = 0;
        wlog.delete(); exp_q.delete();
        add_burst(16'h001A); add_burst(16'h021A); add_burst(16'h021A); add_burst(16'h047B);
        pulse_start();
        check("rerun_done_clr", done, 0);
        check("rerun_busy", busy, 1);
        repeat (20) @(negedge clk);
        check("mid_busy", busy, 1);
        pulse_start();
        wait_flag(500, cyc);
        check("nack1_finished", cyc < 500, 1);
        check("nack1_done", done, 1);
        check("nack1_error", error, 0);
        compare_log("nack1");

        // Entry 0 always NACKs
        mode = 2;
        wlog.delete(); exp_q.delete();
        repeat (4) add_burst(16'h001A);
        pulse_start();
        wait_flag(500, cyc);
        check("nack0_error", error, 1);
        check("nack0_erridx", err_index, 0);
        check("nack0_done", done, 0);
        check("nack0_busy", busy, 0);
        check("nack0_ledr", ledr, 10'b1000000000);
        repeat (50) @(negedge clk);
        compare_log("nack0");

        // Iic_Busy never rises: start timeout on every attempt
        mode = 3;
        wlog.delete(); exp_q.delete();
        repeat (4) add_burst(16'h001A);
        pulse_start();
        wait_flag(500, cyc);
        check("tmo_latency", cyc, 64);
        check("tmo_error", error, 1);
        check("tmo_done", done, 0);
        compare_log("tmo");

        // Reset during WR_REG aborts the burst
        mode = 0;
        wlog.delete(); exp_q.delete();
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        check("wrreg_wr", avalon_write, 1);
        check("wrreg_addr", avalon_address, 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_wrcount", wlog.size(), 2);

        // Restart after reset begins again at entry 0
        wlog.delete(); exp_q.delete();
        add_burst(16'h001A); add_burst(16'h021A); add_burst(16'h047B);
        pulse_start();
        wait_flag(500, cyc);
        check("restart_latency", cyc, 36);
        check("restart_done", done, 1);
        compare_log("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iic_config_sequencer.md
Name: iic_config_sequencer

Overview:
- Parametrised I2C register-configuration sequencer, e.g. for audio codec bring-up.
- Walks a table of NUM_REGS register/data entries and issues one full I2C write per entry.
- Each I2C write is a four-write burst into the IIC_Avalon slave register interface.
- Waits for completion, retries NACKed transfers, and reports progress and status on LED and status outputs.

Parameters:
- NUM_REGS, 10, number of table entries to send (1..2**IDX_W).
- IDX_W, 4, width of the table index.
- DEV_ADDR, 8'h34, I2C device address byte written to slave address 2.
- GAP_CYCLES, 5000, idle Clk_In cycles between consecutive transactions (>=1).
- START_TIMEOUT, 255, cycles to wait for Iic_Busy to rise after the go command.
- MAX_RETRY, 3, retries per entry after NACK or start timeout before flagging error.

Ports:
- Clk_In  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  pulse; begins a sequence from entry 0 when idle, done or error.
- Tbl_Index  out  IDX_W  current table entry index.
- Tbl_Data  in  16  {reg_addr[15:8], reg_data[7:0]}; combinational lookup of Tbl_Index.
- Avalon_Address  out  2  IIC_Avalon register select.
- Avalon_Writedata  out  8  IIC_Avalon write data.
- Avalon_Write  out  1  single-cycle write strobe.
- Iic_Busy  in  1  IIC_Avalon transfer in progress.
- Iic_Nack  in  1  IIC_Avalon last transfer NACKed; valid on Iic_Busy falling edge.
- Busy  out  1  sequence running.
- Done  out  1  all entries acknowledged; sticky until Start or Reset.
- Error  out  1  retries exhausted; sticky until Start or Reset.
- Err_Index  out  IDX_W  entry that failed.
- LEDR  out  10  {Error, Done, Busy, 3'd0, Tbl_Index[3:0]}.

Behaviour:
- Reset values: all outputs 0; state IDLE; index 0; retry count 0; gap counter 0.
- Reset mid-sequence aborts immediately; no further Avalon writes are issued.
- States run in this order: IDLE -> FETCH -> WR_DATA -> WR_REG -> WR_DEV -> WR_GO -> WAIT_START -> WAIT_END -> GAP -> FETCH or FIN.
- IDLE: on Start, clear Done, Error, index and retry count, set Busy, go to FETCH.
  - Start is also accepted in FIN or ERR, same action.
  - Start is ignored while Busy.
- FETCH: one cycle; latch Tbl_Data into the entry register.
- Avalon write burst, one write per cycle, Avalon_Write high exactly one cycle each:
  - WR_DATA: address 0, data reg_data.
  - WR_REG: address 1, data reg_addr.
  - WR_DEV: address 2, data DEV_ADDR.
  - WR_GO: address 3, data 8'h01.
  - Writes occur on 4 consecutive cycles; no waitrequest.
  - Avalon_Address and Avalon_Writedata hold their last value when Avalon_Write is 0.
- WAIT_START: wait for Iic_Busy=1, then go to WAIT_END.
  - If START_TIMEOUT cycles elapse first, treat it as a failure.
- WAIT_END: on Iic_Busy=0, sample Iic_Nack.
  - Iic_Nack=0: success; clear retry count, load gap counter, go to GAP.
  - Iic_Nack=1: failure.
- Failure handling:
  - If retry count < MAX_RETRY: increment it and go to GAP, which then re-runs the same entry without incrementing the index.
  - Otherwise: Error=1, Err_Index=index, Busy=0, go to ERR.
- GAP: count GAP_CYCLES cycles, then:
  - Retry pending: go to FETCH, same index.
  - Index == NUM_REGS-1: go to FIN with Done=1, Busy=0.
  - Otherwise: increment index and go to FETCH.
- Index never wraps; NUM_REGS=1 completes after a single entry.
- Latency for one clean entry with immediate Iic_Busy: 1 FETCH + 4 writes + WAIT_START/WAIT_END durations + GAP_CYCLES.
- Done and Error are never both 1.
- Iic_Busy already high on entry to WAIT_START counts as started.

Test Plan:
- Reset, Start, NUM_REGS=3, table {0x001A, 0x021A, 0x047B}, slave model ACKs -> per entry exactly 4 writes (addr0=1A, addr1=00, addr2=34, addr3=01, and so on); Done=1 after the third entry; Busy=0; LEDR=10'b0100000010.
- NACK on the first attempt of entry 1, then ACK -> entry 1 burst issued twice; Done=1; Error=0; 4*3+4=16 total writes for NUM_REGS=3.
- Entry 0 always NACKs, MAX_RETRY=3 -> 4 bursts; Error=1; Err_Index=0; Done=0; no further writes.
- Iic_Busy never rises -> after START_TIMEOUT cycles each attempt fails; Error=1 after MAX_RETRY+1 bursts.
- Reset asserted during WR_REG -> next cycle all outputs 0 and no Avalon_Write; a new Start restarts from index 0.
- Start pulsed while Busy -> ignored; the sequence completes unchanged; Start in FIN clears Done and reruns.
